// File: rtl/sram_pkg.sv
// Shared SRAM bring-up definitions: geometry, tester state encoding and the address-derived pattern.
package sram_pkg;

  localparam int SRAM_ADDR_BITS = 20;
  localparam int SRAM_DATA_BITS = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_DONE    = 3'd4,
    S_FAIL    = 3'd5
  } state_e;

  // Folding all address bytes together makes address-line shorts and opens show up as data errors.
  function automatic logic [SRAM_DATA_BITS-1:0] pat(input logic [SRAM_ADDR_BITS-1:0] a,
                                                    input logic                      p);
    return a[7:0] ^ a[15:8] ^ {4'h0, a[19:16]} ^ (p ? 8'hFF : 8'h00);
  endfunction

endpackage

// File: rtl/sram_pattern_tester_if.sv
// Request/response port between the pattern tester (master) and the SRAM controller (slave).
interface sram_pattern_tester_if #(
  parameter int ADDR_BITS = 20,
  parameter int DATA_BITS = 8
);

  logic                 o_req;
  logic                 o_we;
  logic [ADDR_BITS-1:0] o_addr;
  logic [DATA_BITS-1:0] o_wdata;
  logic                 i_ready;
  logic                 i_rvalid;
  logic [DATA_BITS-1:0] i_rdata;

  modport master (
    output o_req, o_we, o_addr, o_wdata,
    input  i_ready, i_rvalid, i_rdata
  );

  modport slave (
    input  o_req, o_we, o_addr, o_wdata,
    output i_ready, i_rvalid, i_rdata
  );

endinterface

// File: rtl/sram_pattern_tester.sv
// SRAM self-test: writes pat(addr), reads back and compares, then repeats with inverted data.
// Request outputs are registered; a stalled request holds until accepted, one read outstanding max.
module sram_pattern_tester
  import sram_pkg::*;
#(
  parameter int          ADDR_BITS = SRAM_ADDR_BITS,
  parameter int          DATA_BITS = SRAM_DATA_BITS,
  parameter int unsigned LAST_ADDR = 2**20 - 1,
  parameter int          CBITS     = 26
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  sram_pattern_tester_if.master mem_if,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_fail,
  output logic [ADDR_BITS-1:0]  o_err_addr,
  output logic [DATA_BITS-1:0]  o_err_exp,
  output logic [DATA_BITS-1:0]  o_err_got,
  output logic                  o_led
);

  localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(LAST_ADDR);

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 pass_q, pass_d;
  logic                 req_q, req_d;
  logic                 we_q, we_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic                 done_q, done_d;
  logic                 fail_q, fail_d;
  logic [ADDR_BITS-1:0] err_addr_q, err_addr_d;
  logic [DATA_BITS-1:0] err_exp_q, err_exp_d;
  logic [DATA_BITS-1:0] err_got_q, err_got_d;
  logic [CBITS-1:0]     cnt_q;
  logic                 accept;
  logic [DATA_BITS-1:0] exp_byte;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      pass_q     <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
      err_addr_q <= '0;
      err_exp_q  <= '0;
      err_got_q  <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pass_q     <= pass_d;
      req_q      <= req_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
      err_addr_q <= err_addr_d;
      err_exp_q  <= err_exp_d;
      err_got_q  <= err_got_d;
      cnt_q      <= cnt_q + CBITS'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pass_d     = pass_q;
    done_d     = done_q;
    fail_d     = fail_q;
    err_addr_d = err_addr_q;
    err_exp_d  = err_exp_q;
    err_got_d  = err_got_q;
    accept     = req_q && mem_if.i_ready;
    exp_byte   = DATA_BITS'(pat(SRAM_ADDR_BITS'(addr_q), pass_q));

    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (i_start) begin
          state_d    = S_WR;
          addr_d     = '0;
          pass_d     = 1'b0;
          done_d     = 1'b0;
          fail_d     = 1'b0;
          err_addr_d = '0;
          err_exp_d  = '0;
          err_got_d  = '0;
        end
      end
      S_WR: begin
        if (accept) begin
          if (addr_q == LAST) begin
            addr_d  = '0;
            state_d = S_RD_REQ;
          end else begin
            addr_d = addr_q + ADDR_BITS'(1);
          end
        end
      end
      S_RD_REQ: begin
        if (accept) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (mem_if.i_rvalid) begin
          if (mem_if.i_rdata != exp_byte) begin
            state_d    = S_FAIL;
            fail_d     = 1'b1;
            err_addr_d = addr_q;
            err_exp_d  = exp_byte;
            err_got_d  = mem_if.i_rdata;
          end else if (addr_q != LAST) begin
            addr_d  = addr_q + ADDR_BITS'(1);
            state_d = S_RD_REQ;
          end else if (!pass_q) begin
            pass_d  = 1'b1;
            addr_d  = '0;
            state_d = S_WR;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Request fields come from next-state so they hold steady for as long as the state waits.
    req_d   = (state_d == S_WR) || (state_d == S_RD_REQ);
    we_d    = (state_d == S_WR);
    wdata_d = we_d ? DATA_BITS'(pat(SRAM_ADDR_BITS'(addr_d), pass_d)) : '0;
  end

  assign mem_if.o_req   = req_q;
  assign mem_if.o_we    = we_q;
  assign mem_if.o_addr  = addr_q;
  assign mem_if.o_wdata = wdata_q;

  assign o_busy     = (state_q == S_WR) || (state_q == S_RD_REQ) || (state_q == S_RD_WAIT);
  assign o_done     = done_q;
  assign o_fail     = fail_q;
  assign o_err_addr = err_addr_q;
  assign o_err_exp  = err_exp_q;
  assign o_err_got  = err_got_q;

  always_comb begin
    o_led = 1'b0;
    if (o_busy)                 o_led = cnt_q[CBITS-1];
    else if (state_q == S_DONE) o_led = 1'b1;
    else if (state_q == S_FAIL) o_led = cnt_q[CBITS-4];
  end

endmodule

// File: tb/tb_sram_pattern_tester.sv
// Directed bench for sram_pattern_tester: behavioural controller with stalls and read latency.
module tb_sram_pattern_tester;
  import sram_pkg::*;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic start, start2;
  always #5 clk = ~clk;

  sram_pattern_tester_if #(.ADDR_BITS(4), .DATA_BITS(8)) bus  ();
  sram_pattern_tester_if #(.ADDR_BITS(4), .DATA_BITS(8)) bus2 ();

  logic       busy, done, fail, led;
  logic [3:0] err_addr;
  logic [7:0] err_exp, err_got;
  logic       busy2, done2, fail2, led2;
  logic [3:0] err_addr2;
  logic [7:0] err_exp2, err_got2;

  sram_pattern_tester #(.ADDR_BITS(4), .DATA_BITS(8), .LAST_ADDR(15), .CBITS(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .mem_if(bus),
    .o_busy(busy), .o_done(done), .o_fail(fail), .o_err_addr(err_addr),
    .o_err_exp(err_exp), .o_err_got(err_got), .o_led(led)
  );

  sram_pattern_tester #(.ADDR_BITS(4), .DATA_BITS(8), .LAST_ADDR(0), .CBITS(8)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .mem_if(bus2),
    .o_busy(busy2), .o_done(done2), .o_fail(fail2), .o_err_addr(err_addr2),
    .o_err_exp(err_exp2), .o_err_got(err_got2), .o_led(led2)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- controller model for dut ----------------
  logic        stall_en = 1'b0;
  logic        corrupt_en = 1'b0;
  logic        spur = 1'b0;
  logic        ready_q = 1'b1;
  int          stall_left = 0;
  logic [7:0]  mem [16];
  logic        rd_pend, rv_q;
  int          rd_cnt;
  logic [3:0]  rd_addr;
  logic [7:0]  rdat_q;
  logic [12:0] log_q[$];
  logic        prev_stall;
  logic [12:0] prev_txn;
  int          stab_err = 0;

  assign bus.i_ready  = ready_q;
  assign bus.i_rvalid = rv_q | spur;
  assign bus.i_rdata  = spur ? 8'h55 : rdat_q;

  always @(negedge clk) begin
    if (!stall_en) ready_q <= 1'b1;
    else if (stall_left > 0) begin
      ready_q    <= 1'b0;
      stall_left <= stall_left - 1;
    end else begin
      ready_q    <= 1'b1;
      stall_left <= $urandom_range(0, 5);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= 1'b0;
      rv_q    <= 1'b0;
      rdat_q  <= 8'h00;
      rd_cnt  <= 0;
      rd_addr <= 4'h0;
    end else begin
      rv_q <= 1'b0;
      if (bus.o_req && bus.i_ready) begin
        log_q.push_back({bus.o_we, bus.o_addr, bus.o_wdata});
        if (bus.o_we) mem[bus.o_addr] <= bus.o_wdata;
        else begin
          rd_pend <= 1'b1;
          rd_cnt  <= LAT - 1;
          rd_addr <= bus.o_addr;
        end
      end else if (rd_pend) begin
        if (rd_cnt == 0) begin
          rd_pend <= 1'b0;
          rv_q    <= 1'b1;
          // pass-1 content at address 5 is 8'hFA; flip its LSB when corruption is armed
          rdat_q  <= mem[rd_addr] ^ ((corrupt_en && rd_addr == 4'd5 && mem[rd_addr] == 8'hFA) ? 8'h01 : 8'h00);
        end else begin
          rd_cnt <= rd_cnt - 1;
        end
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
      prev_txn   <= 13'h0;
    end else begin
      if (prev_stall && (!bus.o_req || {bus.o_we, bus.o_addr, bus.o_wdata} != prev_txn))
        stab_err <= stab_err + 1;
      prev_stall <= bus.o_req && !bus.i_ready;
      prev_txn   <= {bus.o_we, bus.o_addr, bus.o_wdata};
    end
  end

  // ---------------- controller model for dut2 (single location) ----------------
  logic [7:0]  mem2;
  logic        r2pend, rv2;
  logic [12:0] log2[$];

  assign bus2.i_ready  = 1'b1;
  assign bus2.i_rvalid = rv2;
  assign bus2.i_rdata  = mem2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2pend <= 1'b0;
      rv2    <= 1'b0;
      mem2   <= 8'h00;
    end else begin
      rv2    <= r2pend;
      r2pend <= 1'b0;
      if (bus2.o_req) begin
        log2.push_back({bus2.o_we, bus2.o_addr, bus2.o_wdata});
        if (bus2.o_we) mem2 <= bus2.o_wdata;
        else           r2pend <= 1'b1;
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [12:0] exp_txn(input int i);
    logic [3:0] a;
    logic       we, p;
    logic [7:0] wd;
    a  = 4'(i % 16);
    we = ((i / 16) % 2) == 0;
    p  = (i / 16) >= 2;
    wd = we ? ({4'h0, a} ^ (p ? 8'hFF : 8'h00)) : 8'h00;
    return {we, a, wd};
  endfunction

  task automatic check_log(input string tag, input int base, input int len);
    int got_len;
    got_len = log_q.size() - base;
    check_eq({tag, "_len"}, 64'(got_len), 64'(len));
    for (int i = 0; i < len && i < got_len; i++)
      check_eq($sformatf("%s_txn%0d", tag, i), 64'(log_q[base + i]), 64'(exp_txn(i)));
  endtask

  task automatic pulse_start;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n;
    n = 0;
    while (!(done || fail) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_finished"}, 64'(done || fail), 64'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    repeat (3) @(negedge clk);

    check_eq("rst_req",   64'(bus.o_req),   64'd0);
    check_eq("rst_we",    64'(bus.o_we),    64'd0);
    check_eq("rst_addr",  64'(bus.o_addr),  64'd0);
    check_eq("rst_wdata", 64'(bus.o_wdata), 64'd0);
    check_eq("rst_flags", 64'({busy, done, fail, led}), 64'd0);
    check_eq("rst_err",   64'({err_addr, err_exp, err_got}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: clean run, no stalls
    base = log_q.size();
    pulse_start();
    check_eq("s1_busy", 64'(busy), 64'd1);
    wait_end("s1");
    check_eq("s1_result", 64'({done, fail, led, busy}), 64'b1010);
    check_log("s1", base, 64);

    // 2: corrupted byte at address 5 in the inverted pass
    corrupt_en = 1'b1;
    base = log_q.size();
    pulse_start();
    check_eq("s2_done_cleared", 64'(done), 64'd0);
    wait_end("s2");
    check_eq("s2_fail", 64'({done, fail}), 64'b01);
    check_eq("s2_err_addr", 64'(err_addr), 64'h5);
    check_eq("s2_err_exp",  64'(err_exp),  64'hFA);
    check_eq("s2_err_got",  64'(err_got),  64'hFB);
    repeat (20) @(negedge clk);
    check_eq("s2_no_more_req", 64'(bus.o_req), 64'd0);
    check_log("s2", base, 54);
    corrupt_en = 1'b0;

    // 3: random ready stalls
    stall_en = 1'b1;
    base = log_q.size();
    pulse_start();
    check_eq("s3_fail_cleared", 64'({fail, err_addr, err_exp, err_got}), 64'd0);
    wait_end("s3");
    check_eq("s3_result", 64'({done, fail}), 64'b10);
    check_eq("s3_stability", 64'(stab_err), 64'd0);
    check_log("s3", base, 64);
    stall_en = 1'b0;
    repeat (8) @(negedge clk);

    // 4: reset while writing address 7, then restart
    pulse_start();
    for (int n = 0; n < 300 && !(bus.o_req && bus.o_we && bus.o_addr == 4'd7); n++) @(negedge clk);
    check_eq("s4_reached_wr7", 64'({bus.o_req, bus.o_we, bus.o_addr}), 64'b1_1_0111);
    rst_n = 1'b0;
    #1;
    check_eq("s4_rst_bus", 64'({bus.o_req, bus.o_we, bus.o_addr, bus.o_wdata}), 64'd0);
    check_eq("s4_rst_flags", 64'({busy, done, fail, led}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("s4_idle", 64'({busy, bus.o_req}), 64'd0);
    base = log_q.size();
    pulse_start();
    check_eq("s4_restart", 64'({bus.o_req, bus.o_we, bus.o_addr}), 64'b1_1_0000);
    wait_end("s4");
    check_eq("s4_result", 64'({done, fail}), 64'b10);
    check_log("s4", base, 64);

    // 5: spurious rvalid during writes and a start pulse mid-test
    base = log_q.size();
    pulse_start();
    for (int n = 0; n < 300 && !(bus.o_req && bus.o_we && bus.o_addr == 4'd3); n++) @(negedge clk);
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    for (int n = 0; n < 300 && !(bus.o_req && bus.o_we && bus.o_addr == 4'd10); n++) @(negedge clk);
    pulse_start();
    wait_end("s5");
    check_eq("s5_result", 64'({done, fail}), 64'b10);
    check_log("s5", base, 64);

    // 6: single-location sweep
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int n = 0; n < 200 && !(done2 || fail2); n++) @(negedge clk);
    check_eq("s6_result", 64'({done2, fail2, busy2, led2}), 64'b1001);
    check_eq("s6_err", 64'({err_addr2, err_exp2, err_got2}), 64'd0);
    check_eq("s6_len", 64'(log2.size()), 64'd4);
    if (log2.size() == 4) begin
      check_eq("s6_w0",  64'(log2[0]), 64'({1'b1, 4'h0, 8'h00}));
      check_eq("s6_r0",  64'(log2[1]), 64'({1'b0, 4'h0, 8'h00}));
      check_eq("s6_w0i", 64'(log2[2]), 64'({1'b1, 4'h0, 8'hFF}));
      check_eq("s6_r0i", 64'(log2[3]), 64'({1'b0, 4'h0, 8'h00}));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
